// File: rtl/leds_racer_pkg.sv
// Shared types and board defaults for the racer LED strip driver.
// Optional build macro: LEDS_RACER_DIM_EN (quarter-brightness colour load).
package leds_racer_pkg;

    // GRB colour as the WS2812 expects it on the wire: G first, B last.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_LOAD,
        ST_BIT,
        ST_LATCH
    } state_t;

    // Default timing for the 50 MHz board clock.
    localparam int DEF_MAX_POS   = 109;
    localparam int DEF_T0H_CLK   = 20;
    localparam int DEF_T1H_CLK   = 40;
    localparam int DEF_BIT_CLK   = 63;
    localparam int DEF_RESET_CLK = 2750;

    // Quarter brightness: every channel shifted right by two.
    function automatic logic [23:0] dim_grb(input logic [23:0] c);
        grb_t p;
        p = c;
        return {p.g >> 2, p.r >> 2, p.b >> 2};
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// One WS2812 bit slot: a go strobe starts a BIT_CLK-cycle period whose high
// time depends on bit_val; last flags the final cycle so the caller can chain
// the next bit back-to-back by asserting go in that cycle.
module ws2812_bit_encoder #(
    parameter int T0H_CLK = 20,
    parameter int T1H_CLK = 40,
    parameter int BIT_CLK = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic bit_val,
    output logic line,
    output logic last
);

    localparam int CW = $clog2(BIT_CLK) + 1;

    logic          active_reg, active_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] high_len;

    assign high_len = bit_val ? CW'(T1H_CLK) : CW'(T0H_CLK);
    assign last     = active_reg && (cnt_reg == CW'(BIT_CLK - 1));
    assign line     = active_reg && (cnt_reg < high_len);

    // Next slot counter: go (re)starts at zero, otherwise count to the end.
    always_comb begin
        active_next = active_reg;
        cnt_next    = cnt_reg;
        if (go) begin
            active_next = 1'b1;
            cnt_next    = '0;
        end else if (last) begin
            active_next = 1'b0;
        end else if (active_reg) begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    // Slot counter register; reset forces the line low on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            active_reg <= active_next;
            cnt_reg    <= cnt_next;
        end
    end

endmodule

// File: rtl/ws2812_frame_driver.sv
// Walks led_index over the strip, fetches each GRB colour from the game core
// (one cycle of registered lookup latency), serialises it MSB first and ends
// the frame with a latch gap. Optional build macro: LEDS_RACER_DIM_EN.
module ws2812_frame_driver
    import leds_racer_pkg::*;
#(
    parameter int MAX_POS   = DEF_MAX_POS,
    parameter int T0H_CLK   = DEF_T0H_CLK,
    parameter int T1H_CLK   = DEF_T1H_CLK,
    parameter int BIT_CLK   = DEF_BIT_CLK,
    parameter int RESET_CLK = DEF_RESET_CLK,
    localparam int IDX_W    = (MAX_POS > 1) ? $clog2(MAX_POS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      color,
    output logic [IDX_W-1:0] led_index,
    output logic             busy,
    output logic             frame_done,
    output logic             leds_line
);

    localparam int LW = $clog2(RESET_CLK) + 1;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [23:0]      shift_reg, shift_next;
    logic [4:0]       bit_cnt_reg, bit_cnt_next;
    logic [LW-1:0]    latch_cnt_reg, latch_cnt_next;
    logic             from_frame_reg, from_frame_next;
    logic             frame_done_reg, frame_done_next;
    logic             enc_go;
    logic             enc_last;
    logic [23:0]      load_color;

`ifdef LEDS_RACER_DIM_EN
    assign load_color = dim_grb(color);
`else
    assign load_color = color;
`endif

    ws2812_bit_encoder #(
        .T0H_CLK(T0H_CLK),
        .T1H_CLK(T1H_CLK),
        .BIT_CLK(BIT_CLK)
    ) u_enc (
        .clk    (clk),
        .rst    (rst),
        .go     (enc_go),
        .bit_val(shift_reg[23]),
        .line   (leds_line),
        .last   (enc_last)
    );

    assign led_index  = idx_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = frame_done_reg;

    // Frame sequencing: next state, index, shift register and latch timer.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        latch_cnt_next  = latch_cnt_reg;
        from_frame_next = from_frame_reg;
        frame_done_next = 1'b0;
        enc_go          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_PREP;
                    idx_next   = '0;
                end
            end
            ST_PREP: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                shift_next   = load_color;
                bit_cnt_next = 5'd23;
                enc_go       = 1'b1;
                state_next   = ST_BIT;
            end
            ST_BIT: begin
                if (enc_last) begin
                    if (bit_cnt_reg != 5'd0) begin
                        shift_next   = {shift_reg[22:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg - 5'd1;
                        enc_go       = 1'b1;
                    end else if (idx_reg == IDX_W'(MAX_POS - 1)) begin
                        state_next      = ST_LATCH;
                        latch_cnt_next  = '0;
                        from_frame_next = 1'b1;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = ST_PREP;
                    end
                end
            end
            ST_LATCH: begin
                if (latch_cnt_reg == LW'(RESET_CLK - 1)) begin
                    state_next      = ST_IDLE;
                    frame_done_next = from_frame_reg;
                    from_frame_next = 1'b0;
                end else begin
                    latch_cnt_next = latch_cnt_reg + LW'(1);
                end
            end
            default: ;
        endcase
    end

    // State register; reset lands in LATCH so a full gap always follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_LATCH;
            idx_reg        <= '0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            latch_cnt_reg  <= '0;
            from_frame_reg <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            latch_cnt_reg  <= latch_cnt_next;
            from_frame_reg <= from_frame_next;
            frame_done_reg <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Self-checking bench for ws2812_frame_driver with a small strip and short
// timing. Expected waveforms come from a frame-level model built from the
// colour table; the upstream core is modelled as a 1-cycle registered lookup.
module tb_ws2812_frame_driver;

    localparam int MAX_POS   = 2;
    localparam int T0H_CLK   = 2;
    localparam int T1H_CLK   = 4;
    localparam int BIT_CLK   = 6;
    localparam int RESET_CLK = 10;
    localparam int FL        = MAX_POS * (2 + 24 * BIT_CLK) + RESET_CLK;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] color;
    logic [0:0]  led_index;
    logic        busy;
    logic        frame_done;
    logic        leds_line;

    logic [23:0] led_color [MAX_POS];
    bit          exp_line [$];
    int          exp_idx [$];
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [23:0] c0;
        logic [23:0] c1;
        int          exp_high;
        int          exp_high_dim;
    } vec_t;

    ws2812_frame_driver #(
        .MAX_POS  (MAX_POS),
        .T0H_CLK  (T0H_CLK),
        .T1H_CLK  (T1H_CLK),
        .BIT_CLK  (BIT_CLK),
        .RESET_CLK(RESET_CLK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .color     (color),
        .led_index (led_index),
        .busy      (busy),
        .frame_done(frame_done),
        .leds_line (leds_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_trace(input string name, input int bad_k, input int got, input int exp);
        tests++;
        if (bad_k >= 0) begin
            fails++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, bad_k, got, exp);
        end
    endtask

    // One clock; the upstream core answers for the index seen last cycle.
    task automatic tick();
        logic [0:0] prev;
        prev = led_index;
        @(posedge clk);
        #1;
        color = led_color[prev];
    endtask

    function automatic logic [23:0] eff_color(input logic [23:0] c);
        logic [7:0] g, r, b;
        g = c[23:16];
        r = c[15:8];
        b = c[7:0];
`ifdef LEDS_RACER_DIM_EN
        g = g / 8'd4;
        r = r / 8'd4;
        b = b / 8'd4;
`endif
        return {g, r, b};
    endfunction

    // Expected line and index for every cycle from the start edge onwards.
    task automatic build_model();
        logic [23:0] c;
        int h;
        exp_line.delete();
        exp_idx.delete();
        for (int led = 0; led < MAX_POS; led++) begin
            c = eff_color(led_color[led]);
            repeat (2) begin
                exp_line.push_back(1'b0);
                exp_idx.push_back(led);
            end
            for (int b = 23; b >= 0; b--) begin
                h = c[b] ? T1H_CLK : T0H_CLK;
                for (int t = 0; t < BIT_CLK; t++) begin
                    exp_line.push_back(t < h);
                    exp_idx.push_back(led);
                end
            end
        end
        for (int r = 0; r < RESET_CLK; r++) begin
            exp_line.push_back(1'b0);
            exp_idx.push_back(MAX_POS - 1);
        end
    endtask

    // Start a frame now, optionally pulse start at cycles g0/g1, and compare
    // the whole frame to the model; ends in the frame_done cycle.
    task automatic run_frame(input string name, input int g0, input int g1, input int exp_high);
        int bl = -1, bla = 0, ble = 0;
        int bi = -1, bia = 0, bie = 0;
        int bb = -1;
        int fd_at = -1;
        int highs = 0;
        build_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= FL; k++) begin
            if (k < FL) begin
                if (leds_line !== exp_line[k] && bl < 0) begin
                    bl = k; bla = int'(leds_line); ble = int'(exp_line[k]);
                end
                if (int'(led_index) != exp_idx[k] && bi < 0) begin
                    bi = k; bia = int'(led_index); bie = exp_idx[k];
                end
                if (busy !== 1'b1 && bb < 0) bb = k;
                highs += int'(leds_line);
            end
            if (frame_done === 1'b1 && fd_at < 0) fd_at = k;
            if (k < FL) begin
                if (k == g0 || k == g1) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        check_trace({name, "_line"}, bl, bla, ble);
        check_trace({name, "_index"}, bi, bia, bie);
        check_trace({name, "_busy"}, bb, 0, 1);
        check({name, "_done_cycle"}, fd_at, FL);
        check({name, "_busy_end"}, int'(busy), 0);
        if (exp_high >= 0) check({name, "_high_cycles"}, highs, exp_high);
        $display("[TB] frame %s c0=%06h c1=%06h high=%0d done@%0d", name,
                 led_color[0], led_color[1], highs, fd_at);
    endtask

    // After a reset edge: ten latch cycles busy and low, then idle, no done.
    task automatic check_latch_gap(input string name);
        int bb = -1, bl = -1, bf = -1;
        for (int i = 0; i < RESET_CLK; i++) begin
            if (busy !== 1'b1 && bb < 0) bb = i;
            if (leds_line !== 1'b0 && bl < 0) bl = i;
            if (frame_done !== 1'b0 && bf < 0) bf = i;
            tick();
        end
        for (int i = RESET_CLK; i < RESET_CLK + 10; i++) begin
            if (leds_line !== 1'b0 && bl < 0) bl = i;
            if (frame_done !== 1'b0 && bf < 0) bf = i;
            if (i == RESET_CLK) check({name, "_idle_busy"}, int'(busy), 0);
            tick();
        end
        check_trace({name, "_gap_busy"}, bb, 0, 1);
        check_trace({name, "_gap_line"}, bl, 1, 0);
        check_trace({name, "_no_done"}, bf, 1, 0);
        $display("[TB] latch gap %s", name);
    endtask

    initial begin
        vec_t vecs [4];
        vecs[0] = '{24'hFF0000, 24'h000001, 114, 108};
        vecs[1] = '{24'h000000, 24'h000000, 96, 96};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 192, 168};
        vecs[3] = '{24'hAAAAAA, 24'h0F0F0F, 144, 126};

        rst = 1'b1;
        start = 1'b0;
        color = 24'h0;
        led_color[0] = 24'h0;
        led_color[1] = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_line", int'(leds_line), 0);
        check("reset_busy", int'(busy), 1);
        check("reset_done", int'(frame_done), 0);
        check("reset_index", int'(led_index), 0);
        rst = 1'b0;
        check_latch_gap("power_on");

        // Table-driven frames, each started in the previous frame_done cycle.
        for (int v = 0; v < 4; v++) begin
            led_color[0] = vecs[v].c0;
            led_color[1] = vecs[v].c1;
`ifdef LEDS_RACER_DIM_EN
            run_frame($sformatf("vec%0d", v), -1, -1, vecs[v].exp_high_dim);
`else
            run_frame($sformatf("vec%0d", v), -1, -1, vecs[v].exp_high);
`endif
        end

        // Random colours against the model.
        for (int r = 0; r < 6; r++) begin
            led_color[0] = 24'($urandom());
            led_color[1] = 24'($urandom());
            run_frame($sformatf("rand%0d", r), -1, -1, -1);
        end

        // Start pulses during BIT and during LATCH are ignored.
        led_color[0] = 24'h5A3C81;
        led_color[1] = 24'hC30F66;
        run_frame("start_while_busy", 20, FL - 6, -1);
        begin
            int bad = -1;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (busy !== 1'b0 && bad < 0) bad = i;
            end
            check_trace("no_second_frame", bad, 1, 0);
        end

        // Reset in the middle of a frame.
        led_color[0] = 24'hFFFFFF;
        led_color[1] = 24'hFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        check("midrst_line_before", int'(leds_line), 1);
        rst = 1'b1;
        tick();
        check("midrst_line_low", int'(leds_line), 0);
        check("midrst_index", int'(led_index), 0);
        rst = 1'b0;
        check_latch_gap("mid_frame_reset");
        led_color[0] = 24'h123456;
        led_color[1] = 24'h89ABCD;
        run_frame("after_reset", -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
